dram_arbiter: RTL and testbench

- Shares one single-port synchronous data RAM between two requesters:
  - port 0: bcpu data port
  - port 1: loader/debug master
- One transaction granted per cycle.
- Round-robin or fixed-priority arbitration.
- Optional lock lets a requester hold the RAM for an atomic read-modify-write sequence.
- Sits between bcpu/loader and the dram block inside cpu_wrapper.

---
 rtl/dram_arbiter.sv | 142 ++++++++++++++
 tb/tb_dram_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one single-port synchronous data RAM between the bcpu data port (0)
// and the loader/debug master (1). Define DRAM_ARB_RR_EN for round-robin, else port 0 has fixed priority.
module dram_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_we,
    input  logic [DATA_W/8-1:0] req0_be,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [DATA_W-1:0]   req0_wdata,
    input  logic                req0_lock,
    output logic                rsp0_valid,
    output logic [DATA_W-1:0]   rsp0_rdata,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_we,
    input  logic [DATA_W/8-1:0] req1_be,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [DATA_W-1:0]   req1_wdata,
    input  logic                req1_lock,
    output logic                rsp1_valid,
    output logic [DATA_W-1:0]   rsp1_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t     state, state_next;
    logic       last_grant, last_grant_next;
    logic [3:0] lock_cnt, lock_cnt_next, cnt_inc;
    logic       rd_pend, rd_pend_next;
    logic       rd_tag, rd_tag_next;
    logic       gnt0, gnt1, accept, acc_lock;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
`ifdef DRAM_ARB_RR_EN
                        gnt0 = last_grant;
                        gnt1 = !last_grant;
`else
                        gnt0 = 1'b1;
`endif
                    end else begin
                        gnt0 = req0_valid;
                        gnt1 = req1_valid;
                    end
                end
                LOCK0:   gnt0 = req0_valid;
                LOCK1:   gnt1 = req1_valid;
                default: ;
            endcase
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;
    assign acc_lock   = gnt1 ? req1_lock : req0_lock;

    always_comb begin
        mem_en    = accept;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt1) begin
            mem_we    = req1_we;
            mem_be    = req1_be;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end else if (gnt0) begin
            mem_we    = req0_we;
            mem_be    = req0_be;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end
    end

    always_comb begin
        state_next      = state;
        lock_cnt_next   = lock_cnt;
        last_grant_next = last_grant;
        rd_pend_next    = accept && !mem_we;
        rd_tag_next     = gnt1;
        cnt_inc         = lock_cnt + 4'd1;
        if (accept) begin
            last_grant_next = gnt1;
            if (state == IDLE) begin
                // A single-beat lock budget releases on the same beat that would take it.
                if (acc_lock && LOCK_MAX > 1) begin
                    state_next    = gnt1 ? LOCK1 : LOCK0;
                    lock_cnt_next = 4'd1;
                end
            end else if (!acc_lock || cnt_inc >= LOCK_MAX_C) begin
                state_next    = IDLE;
                lock_cnt_next = '0;
            end else begin
                lock_cnt_next = cnt_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lock_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_tag     <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            lock_cnt   <= lock_cnt_next;
            rd_pend    <= rd_pend_next;
            rd_tag     <= rd_tag_next;
        end
    end

    // RAM data arrives one cycle after the read; the registered tag steers it to the issuer.
    assign rsp0_valid = rd_pend && !rd_tag;
    assign rsp1_valid = rd_pend && rd_tag;
    assign rsp0_rdata = rsp0_valid ? mem_rdata : '0;
    assign rsp1_rdata = rsp1_valid ? mem_rdata : '0;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed and randomized checks of dram_arbiter against a transaction-level model.
// Expectations follow DRAM_ARB_RR_EN exactly as the design is built.
module tb_dram_arbiter;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int LOCK_MAX = 4;
    localparam int BE_W     = DATA_W / 8;
`ifdef DRAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] valid, we, lock;
    logic [BE_W-1:0]   be    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];

    logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
    logic              mem_en, mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(valid[0]), .req0_ready(req0_ready), .req0_we(we[0]), .req0_be(be[0]),
        .req0_addr(addr[0]), .req0_wdata(wdata[0]), .req0_lock(lock[0]),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(valid[1]), .req1_ready(req1_ready), .req1_we(we[1]), .req1_be(be[1]),
        .req1_addr(addr[1]), .req1_wdata(wdata[1]), .req1_lock(lock[1]),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DATA_W-1:0] ram [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_be[b]) ram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[5:0]];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model: lock owner (-1 = none), beats granted inside the lock, last grant,
    // expected RAM contents and the read response owed next cycle.
    int owner, beats, last, exp_g, acc_g;
    bit pend;
    int pend_port;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] shadow [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        beats = 0;
        last  = 1;
        pend  = 1'b0;
        exp_g = -1;
        acc_g = -1;
    endtask

    // Compare every DUT output against the model in the middle of the cycle.
    task automatic sample();
        @(negedge clk);
        exp_g = -1;
        if (rst) begin
            if (owner >= 0) begin
                if (valid[owner]) exp_g = owner;
            end else if (valid[0] && valid[1]) exp_g = (RR && last == 0) ? 1 : 0;
            else if (valid[0]) exp_g = 0;
            else if (valid[1]) exp_g = 1;
        end
        check("req0_ready", req0_ready, exp_g == 0);
        check("req1_ready", req1_ready, exp_g == 1);
        check("mem_en", mem_en, exp_g >= 0);
        if (exp_g >= 0) begin
            check("mem_we", mem_we, we[exp_g]);
            check("mem_addr", mem_addr, addr[exp_g]);
            if (we[exp_g]) begin
                check("mem_be", mem_be, be[exp_g]);
                check("mem_wdata", mem_wdata, wdata[exp_g]);
            end
        end
        check("rsp0_valid", rsp0_valid, pend && pend_port == 0);
        check("rsp1_valid", rsp1_valid, pend && pend_port == 1);
        if (pend) check("rsp_rdata", pend_port == 0 ? rsp0_rdata : rsp1_rdata, pend_data);
    endtask

    // Apply the beat granted at this edge to the model.
    task automatic advance();
        @(posedge clk);
        #1;
        pend  = 1'b0;
        acc_g = exp_g;
        if (exp_g >= 0) begin
            last = exp_g;
            if (!we[exp_g]) begin
                pend      = 1'b1;
                pend_port = exp_g;
                pend_data = shadow[addr[exp_g][5:0]];
            end else begin
                for (int b = 0; b < BE_W; b++)
                    if (be[exp_g][b]) shadow[addr[exp_g][5:0]][8*b +: 8] = wdata[exp_g][8*b +: 8];
            end
            if (owner < 0) begin
                if (lock[exp_g]) begin
                    beats = 1;
                    if (beats < LOCK_MAX) owner = exp_g;
                end
            end else begin
                beats++;
                if (!lock[exp_g] || beats >= LOCK_MAX) owner = -1;
            end
        end
    endtask

    task automatic set_req(input int p, input bit v, input bit w, input logic [BE_W-1:0] b,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit l);
        valid[p] = v; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d; lock[p] = l;
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 64; i++) begin
            ram[i]    = 32'h1357_0000 + 32'(i) * 32'h0001_0203;
            shadow[i] = 32'h1357_0000 + 32'(i) * 32'h0001_0203;
        end
        ram[4]     = 32'hAABB_CCDD; shadow[4]  = 32'hAABB_CCDD;
        ram[16]    = 32'hDEAD_BEEF; shadow[16] = 32'hDEAD_BEEF;
        model_reset();

        // Reset: requests present but nothing granted, no responses.
        set_req(0, 1, 0, '0, 32'h10, '0, 0);
        set_req(1, 1, 0, '0, 32'h11, '0, 0);
        sample();
        check("rst_ready0", req0_ready, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        advance();
        rst = 1'b1;

        // Continuous conflict for four cycles.
        for (int k = 0; k < 4; k++) begin
            sample();
            check("conflict_grant1", req1_ready, RR ? (k % 2) : 0);
            if (k == 1) check("conflict_rsp0", rsp0_valid, 1);
            advance();
        end
        valid = 2'b00;
        sample();
        advance();

        // Single read.
        set_req(0, 1, 0, '0, 32'h10, '0, 0);
        sample();
        check("rd_ready0", req0_ready, 1);
        check("rd_mem_en", mem_en, 1);
        check("rd_mem_addr", mem_addr, 32'h10);
        advance();
        valid[0] = 1'b0;
        sample();
        check("rd_rsp0_valid", rsp0_valid, 1);
        check("rd_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
        check("rd_rsp1_valid", rsp1_valid, 0);
        advance();

        // Byte-enabled write then read-back from the same port.
        set_req(1, 1, 1, 4'b0011, 32'h4, 32'h1234_5678, 0);
        sample();
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_be", mem_be, 4'b0011);
        advance();
        set_req(1, 1, 0, '0, 32'h4, '0, 0);
        sample();
        check("wr_no_rsp1", rsp1_valid, 0);
        advance();
        valid[1] = 1'b0;
        sample();
        check("wr_merged", rsp1_rdata, 32'hAABB_5678);
        advance();

        // Locked read-modify-write while port 1 waits.
        set_req(0, 1, 0, '0, 32'h8, '0, 1);
        set_req(1, 1, 0, '0, 32'h11, '0, 0);
        sample();
        check("rmw_rd_ready1", req1_ready, 0);
        advance();
        set_req(0, 1, 1, 4'b1111, 32'h8, 32'hCAFE_F00D, 0);
        sample();
        check("rmw_wr_ready1", req1_ready, 0);
        check("rmw_wr_ready0", req0_ready, 1);
        advance();
        valid[0] = 1'b0;
        sample();
        check("rmw_after_ready1", req1_ready, 1);
        advance();
        valid[1] = 1'b0;

        // Forced release after LOCK_MAX locked beats.
        n0 = 0;
        set_req(0, 1, 0, '0, 32'h20, '0, 1);
        set_req(1, 1, 0, '0, 32'h21, '0, 0);
        for (int c = 0; c < 12 && n0 < 6; c++) begin
            sample();
            if (c < 4) check("lock_block1", req1_ready, 0);
            if (c == 4) check("forced_release1", req1_ready, RR);
            advance();
            if (acc_g == 1) valid[1] = 1'b0;
            if (acc_g == 0) begin
                n0++;
                addr[0] = addr[0] + 1;
                if (n0 == 6) valid[0] = 1'b0;
            end
        end
        check("lock_beats_done", n0, 6);
        valid[1] = 1'b0;

        // Reset with a read in flight.
        set_req(0, 1, 0, '0, 32'h10, '0, 0);
        sample();
        advance();
        rst = 1'b0;
        model_reset();
        set_req(1, 1, 0, '0, 32'h11, '0, 0);
        sample();
        check("midrst_rsp0", rsp0_valid, 0);
        check("midrst_ready0", req0_ready, 0);
        advance();
        rst = 1'b1;
        sample();
        check("postrst_ready0", req0_ready, 1);
        check("postrst_rsp0", rsp0_valid, 0);
        advance();

        // Randomized traffic; a requester holds its beat until accepted.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!valid[p] || acc_g == p) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(p, 1, $urandom_range(0, 2) == 0, BE_W'($urandom), 32'($urandom_range(0, 63)),
                                $urandom, $urandom_range(0, 3) == 0);
                    else
                        valid[p] = 1'b0;
                end
            end
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
